// File: rtl/video_types_pkg.sv
// -----------------------------------------------------------------------------
// video_types_pkg
// Shared video types and LCD timing defaults. The renderer and the LCD timing
// controller both take their line counts from here so they cannot drift apart.
// -----------------------------------------------------------------------------
package video_types_pkg;

    // Encoding matches the STAT mode bits seen by software.
    typedef enum logic [1:0] {
        HBLANK = 2'd0,
        VBLANK = 2'd1,
        OAM    = 2'd2,
        XFER   = 2'd3
    } LcdMode;

    localparam int unsigned DOTS_PER_LINE = 456;
    localparam int unsigned OAM_DOTS      = 80;
    localparam int unsigned XFER_DOTS     = 172;
    localparam int unsigned VISIBLE_LINES = 144;
    localparam int unsigned TOTAL_LINES   = 154;

    // Number of drawn lines as seen by the background renderer.
    localparam int unsigned LCD_LINES     = VISIBLE_LINES;

    localparam int unsigned DOT_W = 9;
    localparam int unsigned LY_W  = 8;

endpackage

// File: rtl/lcd_stat_irq.sv
// -----------------------------------------------------------------------------
// lcd_stat_irq
// Builds the STAT interrupt line from the selected sources and emits a one-cycle
// request on its rising edge only. While the line stays high, source changes
// (e.g. HBLANK -> OAM) do not produce further requests.
//
// Ports
//   clk_i          system clock
//   reset_i        asynchronous active-high reset
//   enable_i       LCD running; low clears the line register and blocks requests
//   mode_i         current PPU mode
//   coincidence_i  LY == LYC
//   stat_int_en_i  {lyc, oam, vblank, hblank} source enables
//   stat_irq_o     one-cycle interrupt request
// -----------------------------------------------------------------------------
module lcd_stat_irq
    import video_types_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  LcdMode     mode_i,
    input  logic       coincidence_i,
    input  logic [3:0] stat_int_en_i,
    output logic       stat_irq_o
);

    logic stat_line;
    logic line_q;
    logic line_d;

    always_comb begin
        stat_line = (stat_int_en_i[0] && (mode_i == HBLANK)) ||
                    (stat_int_en_i[1] && (mode_i == VBLANK)) ||
                    (stat_int_en_i[2] && (mode_i == OAM))    ||
                    (stat_int_en_i[3] && coincidence_i);
        line_d     = enable_i & stat_line;
        // Coincidence follows lyc combinationally, so the request does too.
        stat_irq_o = enable_i & stat_line & ~line_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            line_q <= 1'b0;
        end else begin
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_timing_ctrl
// Game Boy LCD scan timing: dot/line counters, LY, PPU mode, LY==LYC compare,
// renderer drawline strobe and reset, VBlank and STAT interrupt requests.
//
// Ports
//   clk_i           system clock
//   reset_i         asynchronous active-high reset
//   lcd_enable_i    LCDC bit 7
//   lyc_i           LYC register value
//   stat_int_en_i   STAT[6:3] = {lyc, oam, vblank, hblank} source enables
//   ly_o            current line
//   mode_o          PPU mode (LcdMode encoding)
//   coincidence_o   ly_o == lyc_i (follows lyc_i in the same cycle)
//   drawline_o      one-cycle strobe at the first XFER dot of a visible line
//   render_reset_o  high while reset or LCD disabled
//   vblank_irq_o    one-cycle request at line VISIBLE_LINES, dot 0
//   stat_irq_o      one-cycle request on a rising STAT line
// -----------------------------------------------------------------------------
module lcd_timing_ctrl
    import video_types_pkg::*;
#(
    parameter int unsigned DotsPerLine  = DOTS_PER_LINE,
    parameter int unsigned OamDots      = OAM_DOTS,
    parameter int unsigned XferDots     = XFER_DOTS,
    parameter int unsigned VisibleLines = VISIBLE_LINES,
    parameter int unsigned TotalLines   = TOTAL_LINES
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       lcd_enable_i,
    input  logic [7:0] lyc_i,
    input  logic [3:0] stat_int_en_i,
    output logic [7:0] ly_o,
    output logic [1:0] mode_o,
    output logic       coincidence_o,
    output logic       drawline_o,
    output logic       render_reset_o,
    output logic       vblank_irq_o,
    output logic       stat_irq_o
);

    localparam logic [DOT_W-1:0] DotLast   = DOT_W'(DotsPerLine - 1);
    localparam logic [DOT_W-1:0] DotXfer   = DOT_W'(OamDots);
    localparam logic [DOT_W-1:0] DotHblank = DOT_W'(OamDots + XferDots);
    localparam logic [LY_W-1:0]  LyVblank  = LY_W'(VisibleLines);
    localparam logic [LY_W-1:0]  LyLast    = LY_W'(TotalLines - 1);

    logic [DOT_W-1:0] dot_q, dot_d;
    logic [LY_W-1:0]  ly_q, ly_d;
    logic             en_q, en_d;
    LcdMode           mode_q, mode_d;
    logic             drawline_q, drawline_d;
    logic             vblank_q, vblank_d;
    logic             render_reset_q, render_reset_d;

    function automatic LcdMode mode_of(logic [DOT_W-1:0] dot, logic [LY_W-1:0] ly);
        if (ly >= LyVblank) begin
            return VBLANK;
        end else if (dot < DotXfer) begin
            return OAM;
        end else if (dot < DotHblank) begin
            return XFER;
        end
        return HBLANK;
    endfunction

    // Outputs are registered, so everything is decoded from the next-state
    // counters. The first enabled cycle (en_q still 0) shows dot 0 / line 0.
    always_comb begin
        en_d  = lcd_enable_i;
        dot_d = '0;
        ly_d  = '0;
        if (lcd_enable_i && en_q) begin
            if (dot_q == DotLast) begin
                dot_d = '0;
                ly_d  = (ly_q == LyLast) ? '0 : ly_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
                ly_d  = ly_q;
            end
        end

        mode_d         = en_d ? mode_of(dot_d, ly_d) : HBLANK;
        drawline_d     = en_d && (ly_d < LyVblank) && (dot_d == DotXfer);
        vblank_d       = en_d && (ly_d == LyVblank) && (dot_d == '0);
        render_reset_d = ~en_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dot_q          <= '0;
            ly_q           <= '0;
            en_q           <= 1'b0;
            mode_q         <= HBLANK;
            drawline_q     <= 1'b0;
            vblank_q       <= 1'b0;
            render_reset_q <= 1'b1;
        end else begin
            dot_q          <= dot_d;
            ly_q           <= ly_d;
            en_q           <= en_d;
            mode_q         <= mode_d;
            drawline_q     <= drawline_d;
            vblank_q       <= vblank_d;
            render_reset_q <= render_reset_d;
        end
    end

    assign ly_o           = ly_q;
    assign mode_o         = mode_q;
    assign coincidence_o  = (ly_q == lyc_i);
    assign drawline_o     = drawline_q;
    assign vblank_irq_o   = vblank_q;
    assign render_reset_o = render_reset_q;

    lcd_stat_irq u_stat_irq (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .enable_i      (en_q),
        .mode_i        (mode_q),
        .coincidence_i (coincidence_o),
        .stat_int_en_i (stat_int_en_i),
        .stat_irq_o    (stat_irq_o)
    );

endmodule
